// File: rtl/grant_finish_pkg.sv
// Shared grant type codes, helper decodes and the default finish entry layout
// for the grant/finish unit.
package grant_finish_pkg;

   // Grant type codes (built-in and custom share the 4-bit g_type field).
   localparam logic [3:0] GET_DATA_BLOCK = 4'd5;
   localparam logic [3:0] GRANT_DATA     = 4'd0;
   localparam logic [3:0] PUT_ACK        = 4'd0;

   // Finish entry layout at the default header / manager id widths.
   localparam int FE_HDR_W  = 2;
   localparam int FE_MXID_W = 2;

   typedef struct packed {
      logic [FE_HDR_W-1:0]  src;
      logic [FE_HDR_W-1:0]  dst;
      logic [FE_MXID_W-1:0] mxid;
   } finish_entry_t;

   // A grant carries refill data for built-in GetDataBlock or custom GrantData.
   function automatic logic grant_has_data(input logic builtin, input logic [3:0] gtype);
      return builtin ? (gtype == GET_DATA_BLOCK) : (gtype == GRANT_DATA);
   endfunction

   // Every grant is acknowledged with a finish except a built-in PutAck.
   function automatic logic grant_needs_finish(input logic builtin, input logic [3:0] gtype);
      return !(builtin && (gtype == PUT_ACK));
   endfunction

endpackage

// File: rtl/grant_finish_fifo.sv
// Small FIFO holding pending finish messages; exposes occupancy count.
module grant_finish_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic                       ready_o,
   output logic                       valid_o,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full, empty, do_push, do_pop;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign do_pop  = pop_i & ~empty;
   // A push into a full queue is only safe when the head leaves in the same cycle.
   assign do_push = push_i & (~full | do_pop);

   // Pointer wrap and occupancy update.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; validity is tracked by the count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign ready_o = ~full;
   assign valid_o = ~empty;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/grant_finish_unit.sv
// Grant/finish unit: forwards grant beats as refill, tracks beats per client
// transaction id, and queues one finish per completed grant.
module grant_finish_unit
   import grant_finish_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int BEATS     = 8,
   parameter int HDR_W     = 2,
   parameter int CXID_W    = 2,
   parameter int MXID_W    = 2,
   parameter int FQ_DEPTH  = 2,
   parameter int CLIENT_ID = 1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        grant_valid,
   output logic                        grant_ready,
   input  logic [HDR_W-1:0]            grant_src,
   input  logic [HDR_W-1:0]            grant_dst,
   input  logic [$clog2(BEATS)-1:0]    grant_addr_beat,
   input  logic [CXID_W-1:0]           grant_cxid,
   input  logic [MXID_W-1:0]           grant_mxid,
   input  logic                        grant_builtin,
   input  logic [3:0]                  grant_gtype,
   input  logic [DATA_W-1:0]           grant_data,
   input  logic                        refill_ready,
   output logic                        refill_valid,
   output logic [HDR_W-1:0]            refill_src,
   output logic [HDR_W-1:0]            refill_dst,
   output logic [$clog2(BEATS)-1:0]    refill_addr_beat,
   output logic [CXID_W-1:0]           refill_cxid,
   output logic [MXID_W-1:0]           refill_mxid,
   output logic                        refill_builtin,
   output logic [3:0]                  refill_gtype,
   output logic [DATA_W-1:0]           refill_data,
   input  logic                        finish_ready,
   output logic                        finish_valid,
   output logic [HDR_W-1:0]            finish_src,
   output logic [HDR_W-1:0]            finish_dst,
   output logic [MXID_W-1:0]           finish_mxid,
   output logic                        fq_ready,
   output logic [$clog2(FQ_DEPTH):0]   fq_count,
   output logic                        beat_err
);

   localparam int BEAT_W = $clog2(BEATS);
   localparam int NID    = 2 ** CXID_W;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef struct packed {
      logic [HDR_W-1:0]  src;
      logic [HDR_W-1:0]  dst;
      logic [MXID_W-1:0] mxid;
   } fin_entry_t;

   logic [BEAT_W-1:0] cnt_q [NID];
   logic [BEAT_W-1:0] cnt_d [NID];
   logic [BEAT_W-1:0] cur_cnt;
   logic              beat_err_q, beat_err_d;
   logic              has_data, needs_finish, last, fire, enq, room;
   fin_entry_t        enq_entry, deq_entry;

   assign has_data     = grant_has_data(grant_builtin, grant_gtype);
   assign needs_finish = grant_needs_finish(grant_builtin, grant_gtype);
   assign cur_cnt      = cnt_q[grant_cxid];
   assign last         = has_data ? (cur_cnt == LAST_BEAT) : 1'b1;

   // Grants that need a finish may only pass when the queue has room.
   assign room         = fq_ready | ~needs_finish;
   assign grant_ready  = refill_ready & room;
   assign refill_valid = grant_valid & room;
   assign fire         = grant_valid & grant_ready;
   assign enq          = fire & needs_finish & last;

   assign refill_src       = grant_src;
   assign refill_dst       = grant_dst;
   assign refill_addr_beat = grant_addr_beat;
   assign refill_cxid      = grant_cxid;
   assign refill_mxid      = grant_mxid;
   assign refill_builtin   = grant_builtin;
   assign refill_gtype     = grant_gtype;
   assign refill_data      = grant_data;

   // Advance only the addressed id's beat counter; wraps at BEATS (power of 2).
   always_comb begin
      cnt_d = cnt_q;
      if (fire && has_data) cnt_d[grant_cxid] = cur_cnt + 1'b1;
      beat_err_d = beat_err_q | (fire & has_data & (grant_addr_beat != cur_cnt));
   end

   // Beat counters and sticky beat-order error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NID; i++) cnt_q[i] <= '0;
         beat_err_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         beat_err_q <= beat_err_d;
      end
   end

   assign beat_err = beat_err_q;

   assign enq_entry.src  = HDR_W'(CLIENT_ID);
   assign enq_entry.dst  = grant_src;
   assign enq_entry.mxid = grant_mxid;

   grant_finish_fifo #(
      .WIDTH (2*HDR_W + MXID_W),
      .DEPTH (FQ_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (enq),
      .push_data_i (enq_entry),
      .pop_i       (finish_ready),
      .ready_o     (fq_ready),
      .valid_o     (finish_valid),
      .data_o      (deq_entry),
      .count_o     (fq_count)
   );

   assign finish_src  = deq_entry.src;
   assign finish_dst  = deq_entry.dst;
   assign finish_mxid = deq_entry.mxid;

endmodule

// File: doc/grant_finish_unit.md
GRANT_FINISH_UNIT -- requirements
Module: grant_finish_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64, refill data width.
REQ-002 SHALL have parameter BEATS, default 8, beats per multibeat grant (power of 2, >=2).
REQ-003 SHALL have parameter HDR_W, default 2, header src/dst width.
REQ-004 SHALL have parameter CXID_W, default 2, client_xact_id width; one beat counter per ID (2**CXID_W).
REQ-005 SHALL have parameter MXID_W, default 2, manager_xact_id width.
REQ-006 SHALL have parameters FQ_DEPTH, default 2, finish queue depth (>=1); CLIENT_ID, default 1, finish header src.
REQ-007 SHALL have ports clk in 1, clock; reset_n in 1, asynchronous active-low reset.
REQ-008 SHALL have grant_valid in 1; grant_ready out 1; grant_src/grant_dst in HDR_W; grant_addr_beat in log2(BEATS); grant_cxid in CXID_W; grant_mxid in MXID_W; grant_builtin in 1; grant_gtype in 4; grant_data in DATA_W.
REQ-009 SHALL have refill_ready in 1; refill_valid out 1; refill_* outputs mirroring grant payload fields.
REQ-010 SHALL have finish_ready in 1; finish_valid out 1; finish_src out HDR_W; finish_dst out HDR_W; finish_mxid out MXID_W.
REQ-011 SHALL have fq_ready out 1 (queue can accept), fq_count out log2(FQ_DEPTH)+1, beat_err out 1 (sticky).

Function
REQ-012 fire = grant_valid & grant_ready; has_data = builtin ? gtype==GET_DATA_BLOCK(5) : gtype==GRANT_DATA(0); needs_finish = !(builtin & gtype==PUT_ACK(0)).
REQ-013 refill_* payload SHALL be combinational pass-through of grant payload; refill_valid = grant_valid & (fq_ready | !needs_finish); grant_ready = refill_ready & (fq_ready | !needs_finish).
REQ-014 Beat counter cnt[cxid] SHALL increment modulo BEATS on each fire with has_data; other IDs' counters untouched.
REQ-015 last = has_data ? cnt[cxid]==BEATS-1 : 1; finish enqueue SHALL occur exactly on fire & needs_finish & last.
REQ-016 Enqueued entry: finish_src=CLIENT_ID, finish_dst=grant_src, finish_mxid=grant_mxid.
REQ-017 Finish queue SHALL be FIFO, zero-bubble: enqueue and dequeue in the same cycle allowed when full (fq_ready stays 1 only if not full; simultaneous deq does not raise fq_ready same cycle).
REQ-018 finish_valid = queue non-empty; entry appears on finish_* one cycle after enqueue (no flow-through); dequeue on finish_valid & finish_ready.
REQ-019 fq_count SHALL be registered occupancy, +1 enq, -1 deq, unchanged on both.
REQ-020 beat_err SHALL set when fire & has_data & grant_addr_beat != cnt[cxid]; cleared only by reset; data still forwarded.
REQ-021 Interleaved multibeat grants on distinct cxid SHALL be tracked independently; finish order = order of last beats.

Reset
REQ-022 On reset_n low (asynchronous): all cnt=0, queue empty, fq_count=0, beat_err=0, finish_valid=0, fq_ready=1.
REQ-023 Reset mid-burst SHALL discard partial beat counts and queued finishes; deassertion synchronised externally.

Structure
REQ-024 Package grant_finish_pkg SHALL hold g_type constants (GET_DATA_BLOCK=5, GRANT_DATA=0, PUT_ACK=0) and finish entry struct typedef.
REQ-025 FIFO SHALL be sub-module grant_finish_fifo (parametrised width/depth, count output); top holds counters and control.

Verification
REQ-026 Non-builtin gtype 0, 8 beats cxid 0, refill_ready=1, finish_ready=1 -> 8 refill beats, one finish with mxid/dst from grant, after beat 7 +1 cycle.
REQ-027 Builtin gtype 0 (PutAck) single beat with queue full -> grant_ready=1, refill passes, no enqueue, fq_count unchanged.
REQ-028 finish_ready=0, FQ_DEPTH=2, three single-beat builtin gtype 1 grants -> first two accepted, third stalls grant_ready=0 until finish_ready pulse; fq_count 2->1->2.
REQ-029 Interleave cxid 0 and 1 beats of gtype-5 grants alternately -> two finishes, each after own beat 7, correct mxids in order.
REQ-030 addr_beat=3 on first beat of cxid 2 -> beat_err=1 stays set; reset_n low mid-burst -> counters 0, queue empty, beat_err=0 immediately.
